convert_fixed_to_float_seq: RTL
===============================

CONVERT_FIXED_TO_FLOAT_SEQ -- requirements
Module: convert_fixed_to_float_seq

Interface
REQ-001 Parameter P, default 32: width of the fixed-point input and of the float output, in bits.
REQ-002 Parameter W, default 8: exponent width, in bits.
REQ-003 Parameter FRAC, default 26: fraction bits of the input, so value = signed(FIXED) / 2^FRAC.
REQ-004 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 START  input  1  request to convert; sampled only in IDLE.
REQ-007 FIXED  input  32  two's-complement fixed-point operand; sampled on the edge that accepts START.
REQ-008 BUSY  output  1  high while a conversion is in progress (states NORM and PACK).
REQ-009 DONE  output  1  registered, one-cycle pulse: FLOAT holds a new result.
REQ-010 FLOAT  output  32  registered IEEE-754 single-precision result; holds its value until the next DONE.

Function
REQ-011 The block SHALL implement the FSM states IDLE, NORM and PACK.
REQ-012 In IDLE with START=1, the block SHALL capture the following on that edge and go to NORM:
- sign = FIXED[31]
- mag = sign ? (0 - FIXED) : FIXED, as a 32-bit unsigned value, so 0x80000000 gives mag 0x80000000
- exp = 127 + 31 - FRAC (132 at the default FRAC).
REQ-013 In NORM the block SHALL act on each edge as follows:
- mag == 0: set the zero flag and go to PACK
- else if mag[31] == 1: go to PACK
- else: shift mag left by 1, decrement exp by 1, stay in NORM.
REQ-014 In PACK the block SHALL register the result on one edge, assert DONE for that cycle and return to IDLE:
- normal case: FLOAT = {sign, exp[7:0], mag[30:8]}
- zero case: FLOAT = 0x00000000.
REQ-015 The mantissa SHALL be truncated (round toward zero); mag[7:0] is discarded.
REQ-016 Latency SHALL be k+2 edges from the START-accepting edge to the edge that raises DONE, where k = leading zeros of mag; k=0 for a zero operand, maximum 33.
REQ-017 START SHALL be ignored while BUSY=1; FIXED changes during a conversion SHALL NOT affect the result.
REQ-018 The block SHALL accept a new START in IDLE on the cycle right after DONE, for back-to-back operation.
REQ-019 With FRAC=26 the output exponent SHALL stay within 101..132; no overflow, underflow or denormal handling is required.
REQ-020 DONE SHALL be low in every cycle other than the one following the PACK edge.

Reset
REQ-021 On a rising edge with RST=1, the block SHALL:
- set the state to IDLE
- set FLOAT = 0x00000000, DONE = 0, BUSY = 0
- clear sign, mag, exp and the zero flag.
REQ-022 RST SHALL take priority over START on the same edge.
REQ-023 RST asserted mid-conversion SHALL abort the conversion with no DONE pulse; the next START after RST deasserts SHALL convert normally.

Verification
REQ-024 FIXED=0x04000000 (1.0), START pulse -> DONE 7 edges later, FLOAT=0x3F800000; BUSY high for the 7 intervening cycles.
REQ-025 FIXED=0xFC000000 (-1.0) -> FLOAT=0xBF800000. FIXED=0x80000000 -> FLOAT=0xC2000000 (-32.0), latency 2.
REQ-026 FIXED=0x00000001 -> FLOAT=0x32800000, latency 33. FIXED=0x00000000 -> FLOAT=0x00000000, latency 2.
REQ-027 FIXED=0x04000001 -> FLOAT=0x3F800000 (truncation). FIXED=0x06000000 -> FLOAT=0x3FC00000 (1.5).
REQ-028 START re-pulsed with a different FIXED while BUSY -> ignored; result and DONE timing match the first operand. Back-to-back START on the cycle after DONE -> accepted.
REQ-029 RST asserted 3 cycles into the 0x00000001 conversion -> BUSY=0 and FLOAT=0 on the next edge, no DONE; a following START with 0x04000000 -> 0x3F800000.

Source files
------------

// File: rtl/convert_fixed_to_float_seq_if.sv
// rtl/convert_fixed_to_float_seq_if.sv - start/operand request and busy/done/result response bundle
interface convert_fixed_to_float_seq_if #(
    parameter int P = 32
);
    logic         start;
    logic [P-1:0] fixed;
    logic         busy;
    logic         done;
    logic [P-1:0] float;

    modport master (
        output start,
        output fixed,
        input  busy,
        input  done,
        input  float
    );

    modport slave (
        input  start,
        input  fixed,
        output busy,
        output done,
        output float
    );
endinterface

// File: rtl/convert_fixed_to_float_seq.sv
// rtl/convert_fixed_to_float_seq.sv - sequential signed fixed-point to IEEE-754 single converter
module convert_fixed_to_float_seq #(
    parameter int P    = 32,
    parameter int W    = 8,
    parameter int FRAC = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    convert_fixed_to_float_seq_if.slave   bus
);
    localparam int         EXP_BIAS = (1 << (W - 1)) - 1;
    localparam logic [W-1:0] EXP_INIT = W'(EXP_BIAS + P - 1 - FRAC);
    localparam int         MANT_W   = P - 1 - W;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         sign_q;
    logic [P-1:0] mag_q;
    logic [W-1:0] exp_q;
    logic         zero_q;
    logic         done_q;
    logic [P-1:0] float_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if ((mag_q == '0) || mag_q[P-1]) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Normalise one bit per cycle; the magnitude keeps its width so -2^(P-1) needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            float_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sign_q <= bus.fixed[P-1];
                        mag_q  <= bus.fixed[P-1] ? ('0 - bus.fixed) : bus.fixed;
                        exp_q  <= EXP_INIT;
                        zero_q <= 1'b0;
                    end
                end
                NORM: begin
                    if (mag_q == '0) begin
                        zero_q <= 1'b1;
                    end else if (!mag_q[P-1]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - W'(1);
                    end
                end
                PACK: begin
                    done_q  <= 1'b1;
                    float_q <= zero_q ? '0 : {sign_q, exp_q, mag_q[P-2 -: MANT_W]};
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.float = float_q;
endmodule
